// File: rtl/rx_deserializer_align.sv
// Serial-to-parallel 8b/10b receiver front end: shifts in one bit per clock,
// finds K28.5 commas to set the word boundary, and tracks lock.
module rx_deserializer_align #(
  parameter logic [9:0] COMMA_N    = 10'b0011111010,
  parameter logic [9:0] COMMA_P    = 10'b1100000101,
  parameter int         LOCK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       comma_det,
  output logic       locked,
  output logic       align_err
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [3:0] LOCK_CNT  = 4'(LOCK_COUNT);
  // A single comma is enough to lock when LOCK_COUNT is 1.
  localparam logic [1:0] ST_FIRST  = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;

  logic [9:0] r_sr;
  logic [3:0] r_cnt;
  logic [3:0] r_good_cnt;
  logic [1:0] r_state;
  logic [9:0] r_dout;
  logic       r_valid;
  logic       r_comma;
  logic       r_err;

  logic       w_match;
  logic       w_boundary;

  assign w_match    = (r_sr == COMMA_N) || (r_sr == COMMA_P);
  assign w_boundary = (r_cnt == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr       <= '0;
      r_cnt      <= '0;
      r_good_cnt <= '0;
      r_state    <= ST_HUNT;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_comma    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_sr    <= {r_sr[8:0], serial_in};
      r_valid <= 1'b0;
      r_comma <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= (r_cnt == 4'd9) ? 4'd0 : r_cnt + 4'd1;

      case (r_state)
        ST_HUNT: begin
          r_cnt <= '0;
          if (w_match) begin
            r_dout     <= r_sr;
            r_valid    <= 1'b1;
            r_comma    <= 1'b1;
            r_good_cnt <= 4'd1;
            r_state    <= ST_FIRST;
          end
        end
        ST_VERIFY, ST_LOCKED: begin
          if (w_match && !w_boundary) begin
            // Comma off the current boundary: adopt its phase and re-verify.
            r_cnt      <= '0;
            r_dout     <= r_sr;
            r_valid    <= 1'b1;
            r_comma    <= 1'b1;
            r_err      <= 1'b1;
            r_good_cnt <= 4'd1;
            r_state    <= ST_FIRST;
          end else if (w_boundary) begin
            r_dout  <= r_sr;
            r_valid <= 1'b1;
            r_comma <= w_match;
            if (w_match) begin
              if (r_good_cnt < LOCK_CNT) begin
                r_good_cnt <= r_good_cnt + 4'd1;
              end
              if ((r_state == ST_VERIFY) && (r_good_cnt + 4'd1 >= LOCK_CNT)) begin
                r_state <= ST_LOCKED;
              end
            end
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign comma_det  = r_comma;
  assign align_err  = r_err;
  assign locked     = (r_state == ST_LOCKED);

endmodule
